bvurem_inv_search: RTL and testbench

Sequential, width-parametrised witness finder for unsigned-remainder invertibility constraints. Given operands `s`, `t`, an operand position and a comparison predicate, it searches candidates x = 0, 1, …, 2^W−1 in ascending order. It returns the first x that satisfies the constraint, or reports that no solution exists. It generalises the fixed 4-bit combinational Skolem functions in the skolem-function library to any width and to all four unsigned orderings, and it adds a valid/ready handshake. It sits between the constraint front-end and the witness consumer.

---
 rtl/bvurem_inv_pkg.sv | 10 +
 rtl/urem_serial.sv | 51 +++++
 rtl/bvurem_inv_search.sv | 99 +++++++++
 tb/tb_bvurem_inv_search.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bvurem_inv_pkg.sv
// bvurem_inv_pkg: shared types and predicate helper for the urem witness search.
package bvurem_inv_pkg;
  localparam int MAX_W = 16;
  typedef enum logic [1:0] {PRED_ULE, PRED_ULT, PRED_UGE, PRED_UGT} pred_e;
  typedef enum logic {POS_XS, POS_SX} pos_e;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CHECK, S_DONE} state_e;
  function automatic logic pred_eval(input logic [MAX_W-1:0] rem, input logic [MAX_W-1:0] t, input pred_e pred);
    return pred == PRED_ULE ? rem <= t : pred == PRED_ULT ? rem < t : pred == PRED_UGE ? rem >= t : rem > t;
  endfunction
endpackage

// File: rtl/urem_serial.sv
// urem_serial: restoring serial remainder unit, one dividend bit per cycle.
module urem_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] r_q, r_d, q_q, q_d, d_q, d_d, diff;
  logic [CW-1:0] n_q, n_d;
  logic [W:0] sh;
  // a zero divisor always "subtracts", so the remainder becomes the dividend
  always_comb begin
    sh = {r_q, q_q[W-1]};
    diff = sh[W-1:0] - d_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    n_d = n_q;
    if (start) begin
      r_d = '0;
      q_d = dividend;
      d_d = divisor;
      n_d = CW'(W);
    end else if (n_q != '0) begin
      r_d = sh >= {1'b0, d_q} ? diff : sh[W-1:0];
      q_d = {q_q[W-2:0], 1'b0};
      n_d = n_q - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      n_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      n_q <= n_d;
    end
  end
  assign rem = r_q;
  assign done = n_q == CW'(1);
endmodule

// File: rtl/bvurem_inv_search.sv
// bvurem_inv_search: ascending witness search for (x urem s) PRED t / (s urem x) PRED t.
module bvurem_inv_search
  import bvurem_inv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic         pos,
  input  logic [1:0]   pred,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         found
);
  state_e state_q, state_d;
  pred_e pred_q, pred_d;
  pos_e pos_q, pos_d, pos_m;
  logic [W-1:0] cand_q, cand_d, s_q, s_d, t_q, t_d, x_q, x_d;
  logic [W-1:0] cand_n, s_m, dividend, divisor, rem;
  logic found_q, found_d, accept, hit, last, start, done;
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign x = x_q;
  assign found = found_q;
  assign accept = in_valid & in_ready;
  assign hit = pred_eval(MAX_W'(rem), MAX_W'(t_q), pred_q);
  assign last = &cand_q;
  assign start = accept | (state_q == S_CHECK & ~hit & ~last);
  // on accept the divider is fed straight from the ports, as nothing is latched yet
  assign cand_n = accept ? '0 : cand_q + W'(1);
  assign s_m = accept ? s : s_q;
  assign pos_m = accept ? pos_e'(pos) : pos_q;
  assign dividend = pos_m == POS_SX ? s_m : cand_n;
  assign divisor = pos_m == POS_SX ? cand_n : s_m;
  urem_serial #(.W(W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .rem(rem),
    .done(done)
  );
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    s_d = s_q;
    t_d = t_q;
    pos_d = pos_q;
    pred_d = pred_q;
    x_d = x_q;
    found_d = found_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        s_d = s;
        t_d = t;
        pos_d = pos_e'(pos);
        pred_d = pred_e'(pred);
        cand_d = '0;
        state_d = S_DIV;
      end
      S_DIV: state_d = done ? S_CHECK : S_DIV;
      S_CHECK: begin
        x_d = hit ? cand_q : '0;
        found_d = hit;
        cand_d = hit | last ? cand_q : cand_n;
        state_d = hit | last ? S_DONE : S_DIV;
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q <= '0;
      s_q <= '0;
      t_q <= '0;
      pos_q <= POS_XS;
      pred_q <= PRED_ULE;
      x_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      s_q <= s_d;
      t_q <= t_d;
      pos_q <= pos_d;
      pred_q <= pred_d;
      x_q <= x_d;
      found_q <= found_d;
    end
  end
endmodule

// File: tb/tb_bvurem_inv_search.sv
// tb_bvurem_inv_search: directed plan plus random requests against a brute-force model.
module tb_bvurem_inv_search;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, pos = 0;
  logic in_ready, out_valid, found;
  logic [3:0] s = 0, t = 0, x;
  logic [1:0] pred = 0;
  int cyc = 0, checks = 0, errors = 0;
  bvurem_inv_search #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .pos(pos), .pred(pred), .out_valid(out_valid),
    .out_ready(out_ready), .x(x), .found(found)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int ms, mt, mpos, mpred, output int mf, mx, mlat);
    int a, b, r;
    bit ok;
    mf = 0;
    mx = 0;
    mlat = 16 * 5;
    for (int c = 0; c < 16; c++) begin
      a = mpos ? ms : c;
      b = mpos ? c : ms;
      r = b == 0 ? a : a % b;
      ok = mpred == 0 ? r <= mt : mpred == 1 ? r < mt : mpred == 2 ? r >= mt : r > mt;
      if (ok) begin
        mf = 1;
        mx = c;
        mlat = (c + 1) * 5;
        return;
      end
    end
  endfunction
  task automatic run(input int rs, rt, rpos, rpred, hold);
    int e0, n, ef, ex, el;
    model(rs, rt, rpos, rpred, ef, ex, el);
    @(negedge clk);
    s = 4'(rs);
    t = 4'(rt);
    pos = rpos[0];
    pred = 2'(rpred);
    in_valid = 1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    e0 = cyc;
    in_valid = 0;
    s = 4'($urandom);
    t = 4'($urandom);
    pos = 1'($urandom);
    pred = 2'($urandom);
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_timeout", out_valid, 1);
    chk("latency", cyc - e0, el);
    chk("x", x, ex);
    chk("found", found, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_x", x, ex);
      chk("hold_found", found, ef);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_found", found, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(3, 0, 0, 0, 0);
    run(0, 14, 0, 3, 0);
    run(5, 0, 1, 1, 0);
    run(7, 1, 1, 0, 20);
    @(negedge clk);
    s = 5;
    t = 0;
    pos = 1;
    pred = 1;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_x", x, 0);
    chk("arst_found", found, 0);
    @(negedge clk);
    rst_n = 1;
    run(6, 2, 0, 2, 0);
    for (int i = 0; i < 500; i++)
      run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
